// File: rtl/dmac_rd_burst_gen_if.sv
// Bundles for the read burst generator: the controller-facing request channel
// and the AXI4 read-address channel.
interface dmac_rd_req_if #(
  parameter int unsigned ADDR_WD = 32
);
  logic               rd_req_valid;
  logic               rd_req_ack;
  logic [ADDR_WD-1:0] rd_req_addr;
  logic [1:0]         rd_req_burst;
  logic [ADDR_WD-1:0] rd_req_length;
  logic [2:0]         rd_req_size;
  logic [ADDR_WD-1:0] rd_req_next_addr;
  logic [ADDR_WD-1:0] rd_req_next_length;
  logic               rd_req_done;

  modport master (
    output rd_req_valid, rd_req_addr, rd_req_burst, rd_req_length, rd_req_size,
    input  rd_req_ack, rd_req_next_addr, rd_req_next_length, rd_req_done
  );

  modport slave (
    input  rd_req_valid, rd_req_addr, rd_req_burst, rd_req_length, rd_req_size,
    output rd_req_ack, rd_req_next_addr, rd_req_next_length, rd_req_done
  );
endinterface

interface dmac_axi_ar_if #(
  parameter int unsigned ADDR_WD = 32
);
  logic               m_axi_arvalid;
  logic               m_axi_arready;
  logic [ADDR_WD-1:0] m_axi_araddr;
  logic [7:0]         m_axi_arlen;
  logic [2:0]         m_axi_arsize;
  logic [1:0]         m_axi_arburst;

  modport master (
    output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    input  m_axi_arready
  );

  modport slave (
    input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    output m_axi_arready
  );
endinterface

// File: rtl/dmac_rd_burst_gen.sv
// Carves one AXI4 AR burst (capped by MAX_BURST_LEN beats and the 4 KB page)
// from a channel read request and tracks outstanding read bursts.
module dmac_rd_burst_gen #(
  parameter int unsigned ADDR_WD            = 32,
  parameter int unsigned DATA_WD            = 32,
  parameter int unsigned MAX_BURST_LEN      = 16,
  parameter int unsigned RD_MAX_OUTSTANDING = 8,
  localparam int unsigned OUT_WD            = $clog2(RD_MAX_OUTSTANDING) + 1
) (
  input  logic               clk,
  input  logic               rst,
  dmac_rd_req_if.slave       rd_req,
  dmac_axi_ar_if.master      m_axi_ar,
  input  logic               r_last_hs,
  output logic               rd_resp_valid,
  output logic [OUT_WD-1:0]  outstanding
);

  localparam int unsigned STRB_WD  = DATA_WD / 8;
  localparam logic [2:0]  SIZE_MAX = 3'($clog2(STRB_WD));
  localparam logic [1:0]  BURST_FIXED = 2'd0;
  localparam logic [1:0]  BURST_INCR  = 2'd1;

  typedef enum logic [1:0] {IDLE, CALC, ADDR, ACK} state_t;

  state_t             state;
  logic [ADDR_WD-1:0] addr_q;
  logic [ADDR_WD-1:0] len_q;
  logic [1:0]         burst_q;
  logic [2:0]         size_q;

  logic               arvalid_q;
  logic [ADDR_WD-1:0] araddr_q;
  logic [7:0]         arlen_q;
  logic [2:0]         arsize_q;
  logic [1:0]         arburst_q;
  logic               ack_q;
  logic [ADDR_WD-1:0] next_addr_q;
  logic [ADDR_WD-1:0] next_len_q;
  logic               done_q;

  // Burst arithmetic on the latched request
  logic               is_fixed;
  logic [2:0]         sz;
  logic [ADDR_WD-1:0] size_mask;
  logic [ADDR_WD-1:0] off;
  logic [ADDR_WD-1:0] max_bytes;
  logic [ADDR_WD-1:0] cap_burst;
  logic [ADDR_WD-1:0] cap_page;
  logic [ADDR_WD-1:0] bytes_c;
  logic [ADDR_WD-1:0] beats_c;
  logic [7:0]         arlen_c;

  always_comb begin
    is_fixed  = (burst_q == BURST_FIXED);
    sz        = (size_q > SIZE_MAX) ? SIZE_MAX : size_q;
    size_mask = (ADDR_WD'(1) << sz) - ADDR_WD'(1);
    off       = addr_q & size_mask;
    max_bytes = ADDR_WD'(MAX_BURST_LEN) << sz;
    cap_burst = max_bytes - off;
    cap_page  = ADDR_WD'(13'h1000 - {1'b0, addr_q[11:0]});
    bytes_c   = '0;
    beats_c   = '0;
    if (is_fixed) begin
      bytes_c = (len_q < max_bytes) ? len_q : max_bytes;
      beats_c = (bytes_c + size_mask) >> sz;
    end else begin
      // WRAP requests are carved exactly like INCR
      bytes_c = len_q;
      if (cap_burst < bytes_c) bytes_c = cap_burst;
      if (cap_page < bytes_c)  bytes_c = cap_page;
      beats_c = (off + bytes_c + size_mask) >> sz;
    end
    arlen_c = 8'(beats_c - ADDR_WD'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      burst_q     <= '0;
      size_q      <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      arburst_q   <= '0;
      ack_q       <= 1'b0;
      next_addr_q <= '0;
      next_len_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rd_req.rd_req_valid) begin
            addr_q  <= rd_req.rd_req_addr;
            len_q   <= rd_req.rd_req_length;
            burst_q <= rd_req.rd_req_burst;
            size_q  <= rd_req.rd_req_size;
            state   <= CALC;
          end
        end
        CALC: begin
          if (len_q == '0) begin
            next_addr_q <= addr_q;
            next_len_q  <= '0;
            done_q      <= 1'b1;
            ack_q       <= 1'b1;
            state       <= ACK;
          end else if (outstanding < OUT_WD'(RD_MAX_OUTSTANDING)) begin
            araddr_q    <= addr_q;
            arlen_q     <= arlen_c;
            arsize_q    <= sz;
            arburst_q   <= is_fixed ? BURST_FIXED : BURST_INCR;
            next_addr_q <= is_fixed ? addr_q : addr_q + bytes_c;
            next_len_q  <= len_q - bytes_c;
            done_q      <= (len_q == bytes_c);
            arvalid_q   <= 1'b1;
            state       <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi_ar.m_axi_arready) begin
            arvalid_q <= 1'b0;
            ack_q     <= 1'b1;
            state     <= ACK;
          end
        end
        ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic ar_hs;
  assign ar_hs = arvalid_q & m_axi_ar.m_axi_arready;

  // Counter saturates at both ends; a stray RLAST at zero is ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding   <= '0;
      rd_resp_valid <= 1'b0;
    end else begin
      rd_resp_valid <= r_last_hs;
      if (ar_hs && !r_last_hs && outstanding < OUT_WD'(RD_MAX_OUTSTANDING))
        outstanding <= outstanding + OUT_WD'(1);
      else if (!ar_hs && r_last_hs && outstanding != '0)
        outstanding <= outstanding - OUT_WD'(1);
    end
  end

  assign m_axi_ar.m_axi_arvalid = arvalid_q;
  assign m_axi_ar.m_axi_araddr  = araddr_q;
  assign m_axi_ar.m_axi_arlen   = arlen_q;
  assign m_axi_ar.m_axi_arsize  = arsize_q;
  assign m_axi_ar.m_axi_arburst = arburst_q;

  assign rd_req.rd_req_ack         = ack_q;
  assign rd_req.rd_req_next_addr   = next_addr_q;
  assign rd_req.rd_req_next_length = next_len_q;
  assign rd_req.rd_req_done        = done_q;

endmodule

// File: tb/tb_dmac_rd_burst_gen.sv
// Self-checking bench for dmac_rd_burst_gen: directed cases plus randomized
// transfers checked against an arithmetic reference model.
module tb_dmac_rd_burst_gen;

  localparam int unsigned AW   = 32;
  localparam int unsigned MAXB = 16;
  localparam int unsigned MAXO = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       r_last_hs;
  logic       rd_resp_valid;
  logic [1:0] outstanding;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_out   = 0;

  dmac_rd_req_if #(.ADDR_WD(AW)) req_if ();
  dmac_axi_ar_if #(.ADDR_WD(AW)) ar_if ();

  dmac_rd_burst_gen #(
    .ADDR_WD(AW),
    .DATA_WD(32),
    .MAX_BURST_LEN(MAXB),
    .RD_MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rd_req(req_if.slave),
    .m_axi_ar(ar_if.master),
    .r_last_hs(r_last_hs),
    .rd_resp_valid(rd_resp_valid),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic [31:0] next_addr;
    logic [31:0] next_len;
    logic        done;
    logic        issues;
  } exp_t;

  // Reference: byte count is the smallest of the remaining length, the beat cap
  // (less the start offset for INCR) and the distance to the next 4 KB page.
  function automatic exp_t model(input logic [31:0] addr, input logic [31:0] len,
                                 input logic [1:0] burst, input logic [2:0] size);
    longint unsigned unit, off, bytes, beats, a, l;
    exp_t e;
    a = addr; l = len;
    unit = 64'd1 << size;
    off  = a % unit;
    if (burst == 2'd0) begin
      bytes = (l < MAXB * unit) ? l : MAXB * unit;
      beats = (bytes + unit - 1) / unit;
    end else begin
      bytes = l;
      if (MAXB * unit - off < bytes) bytes = MAXB * unit - off;
      if (4096 - (a % 4096) < bytes) bytes = 4096 - (a % 4096);
      beats = (off + bytes + unit - 1) / unit;
    end
    e.araddr    = addr;
    e.arlen     = 8'(beats - 1);
    e.arburst   = (burst == 2'd0) ? 2'd0 : 2'd1;
    e.next_addr = (burst == 2'd0) ? addr : 32'(a + bytes);
    e.next_len  = 32'(l - bytes);
    e.done      = (l == bytes);
    e.issues    = (l != 0);
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [31:0] addr, input logic [31:0] len,
                        input logic [1:0] burst, input logic [2:0] size,
                        input int ready_dly, output exp_t obs);
    exp_t e;
    int   cyc;
    bit   seen;
    e   = model(addr, len, burst, size);
    obs = '{default: '0};
    req_if.rd_req_valid  = 1'b1;
    req_if.rd_req_addr   = addr;
    req_if.rd_req_length = len;
    req_if.rd_req_burst  = burst;
    req_if.rd_req_size   = size;
    if (!e.issues) begin
      tick;
      total_cnt++; if (ar_if.m_axi_arvalid !== 1'b0) $display("FAIL zero_len_noar1: got %b want 0", ar_if.m_axi_arvalid); else pass_cnt++;
      tick;
      total_cnt++; if (ar_if.m_axi_arvalid !== 1'b0) $display("FAIL zero_len_noar2: got %b want 0", ar_if.m_axi_arvalid); else pass_cnt++;
      total_cnt++; if (req_if.rd_req_ack !== 1'b1) $display("FAIL zero_len_ack: got %b want 1", req_if.rd_req_ack); else pass_cnt++;
    end else begin
      seen = 0; cyc = 0;
      while (!seen && cyc < 10) begin
        tick; cyc++;
        if (ar_if.m_axi_arvalid === 1'b1) seen = 1;
      end
      total_cnt++; if (!seen || cyc != 2) $display("FAIL ar_latency: got %0d cycles (seen=%0b) want 2", cyc, seen); else pass_cnt++;
      if (!seen) begin
        req_if.rd_req_valid = 1'b0;
        tick;
        return;
      end
      obs.araddr = ar_if.m_axi_araddr;
      obs.arlen  = ar_if.m_axi_arlen;
      total_cnt++; if (ar_if.m_axi_araddr !== e.araddr) $display("FAIL araddr: got %h want %h", ar_if.m_axi_araddr, e.araddr); else pass_cnt++;
      total_cnt++; if (ar_if.m_axi_arlen !== e.arlen) $display("FAIL arlen: got %0d want %0d (addr %h len %0d burst %0d size %0d)", ar_if.m_axi_arlen, e.arlen, addr, len, burst, size); else pass_cnt++;
      total_cnt++; if (ar_if.m_axi_arsize !== size) $display("FAIL arsize: got %0d want %0d", ar_if.m_axi_arsize, size); else pass_cnt++;
      total_cnt++; if (ar_if.m_axi_arburst !== e.arburst) $display("FAIL arburst: got %0d want %0d", ar_if.m_axi_arburst, e.arburst); else pass_cnt++;
      repeat (ready_dly) begin
        tick;
        total_cnt++; if ({ar_if.m_axi_arvalid, ar_if.m_axi_araddr, ar_if.m_axi_arlen} !== {1'b1, e.araddr, e.arlen}) $display("FAIL ar_stable: got %b/%h/%0d want 1/%h/%0d", ar_if.m_axi_arvalid, ar_if.m_axi_araddr, ar_if.m_axi_arlen, e.araddr, e.arlen); else pass_cnt++;
      end
      ar_if.m_axi_arready = 1'b1;
      tick;
      ar_if.m_axi_arready = 1'b0;
      if (exp_out < int'(MAXO)) exp_out++;
      total_cnt++; if (req_if.rd_req_ack !== 1'b1) $display("FAIL ack_after_hs: got %b want 1", req_if.rd_req_ack); else pass_cnt++;
      total_cnt++; if (ar_if.m_axi_arvalid !== 1'b0) $display("FAIL arvalid_drop: got %b want 0", ar_if.m_axi_arvalid); else pass_cnt++;
      total_cnt++; if (outstanding !== 2'(exp_out)) $display("FAIL outstanding_inc: got %0d want %0d", outstanding, exp_out); else pass_cnt++;
    end
    obs.next_addr = req_if.rd_req_next_addr;
    obs.next_len  = req_if.rd_req_next_length;
    obs.done      = req_if.rd_req_done;
    total_cnt++; if (req_if.rd_req_next_addr !== e.next_addr) $display("FAIL next_addr: got %h want %h", req_if.rd_req_next_addr, e.next_addr); else pass_cnt++;
    total_cnt++; if (req_if.rd_req_next_length !== e.next_len) $display("FAIL next_length: got %0d want %0d", req_if.rd_req_next_length, e.next_len); else pass_cnt++;
    total_cnt++; if (req_if.rd_req_done !== e.done) $display("FAIL done: got %b want %b", req_if.rd_req_done, e.done); else pass_cnt++;
    req_if.rd_req_valid = 1'b0;
    tick;
    total_cnt++; if (req_if.rd_req_ack !== 1'b0) $display("FAIL ack_one_cycle: got %b want 0", req_if.rd_req_ack); else pass_cnt++;
  endtask

  task automatic pulse_rlast;
    r_last_hs = 1'b1;
    tick;
    r_last_hs = 1'b0;
    if (exp_out > 0) exp_out--;
    total_cnt++; if (rd_resp_valid !== 1'b1) $display("FAIL resp_pulse: got %b want 1", rd_resp_valid); else pass_cnt++;
    total_cnt++; if (outstanding !== 2'(exp_out)) $display("FAIL outstanding_dec: got %0d want %0d", outstanding, exp_out); else pass_cnt++;
    tick;
    total_cnt++; if (rd_resp_valid !== 1'b0) $display("FAIL resp_one_cycle: got %b want 0", rd_resp_valid); else pass_cnt++;
  endtask

  task automatic test_reset;
    total_cnt++; if (req_if.rd_req_ack !== 1'b0) $display("FAIL rst_ack: got %b want 0", req_if.rd_req_ack); else pass_cnt++;
    total_cnt++; if (ar_if.m_axi_arvalid !== 1'b0) $display("FAIL rst_arvalid: got %b want 0", ar_if.m_axi_arvalid); else pass_cnt++;
    total_cnt++; if (rd_resp_valid !== 1'b0) $display("FAIL rst_resp: got %b want 0", rd_resp_valid); else pass_cnt++;
    total_cnt++; if (outstanding !== 2'd0) $display("FAIL rst_outstanding: got %0d want 0", outstanding); else pass_cnt++;
    total_cnt++; if (req_if.rd_req_next_length !== 32'd0) $display("FAIL rst_next_length: got %h want 0", req_if.rd_req_next_length); else pass_cnt++;
  endtask

  task automatic test_directed;
    exp_t o;
    do_req(32'h1000, 32'd64, 2'd1, 3'd2, 0, o);
    total_cnt++; if ({o.arlen, o.next_addr, o.next_len, o.done} !== {8'd15, 32'h1040, 32'd0, 1'b1}) $display("FAIL dir_aligned: got %0d/%h/%0d/%b want 15/1040/0/1", o.arlen, o.next_addr, o.next_len, o.done); else pass_cnt++;
    pulse_rlast;
    do_req(32'h0FF0, 32'd256, 2'd1, 3'd2, 1, o);
    total_cnt++; if ({o.arlen, o.next_addr, o.next_len, o.done} !== {8'd3, 32'h1000, 32'd240, 1'b0}) $display("FAIL dir_4k_cap: got %0d/%h/%0d/%b want 3/1000/240/0", o.arlen, o.next_addr, o.next_len, o.done); else pass_cnt++;
    pulse_rlast;
    do_req(32'h1000, 32'd240, 2'd1, 3'd2, 0, o);
    total_cnt++; if ({o.arlen, o.next_len} !== {8'd15, 32'd176}) $display("FAIL dir_followup: got %0d/%0d want 15/176", o.arlen, o.next_len); else pass_cnt++;
    pulse_rlast;
    do_req(32'h1002, 32'd8, 2'd1, 3'd2, 2, o);
    total_cnt++; if ({o.araddr, o.arlen, o.next_addr, o.done} !== {32'h1002, 8'd2, 32'h100A, 1'b1}) $display("FAIL dir_unaligned: got %h/%0d/%h/%b want 1002/2/100a/1", o.araddr, o.arlen, o.next_addr, o.done); else pass_cnt++;
    pulse_rlast;
    do_req(32'h2000, 32'd100, 2'd0, 3'd2, 0, o);
    total_cnt++; if ({o.arlen, o.next_addr, o.next_len} !== {8'd15, 32'h2000, 32'd36}) $display("FAIL dir_fixed: got %0d/%h/%0d want 15/2000/36", o.arlen, o.next_addr, o.next_len); else pass_cnt++;
    pulse_rlast;
  endtask

  task automatic test_zero_len;
    exp_t o;
    do_req(32'h3456, 32'd0, 2'd1, 3'd1, 0, o);
    total_cnt++; if ({o.next_addr, o.next_len, o.done} !== {32'h3456, 32'd0, 1'b1}) $display("FAIL zero_len_fields: got %h/%0d/%b want 3456/0/1", o.next_addr, o.next_len, o.done); else pass_cnt++;
    total_cnt++; if (outstanding !== 2'd0) $display("FAIL zero_len_outstanding: got %0d want 0", outstanding); else pass_cnt++;
  endtask

  task automatic test_saturate;
    pulse_rlast;
  endtask

  task automatic test_outstanding;
    exp_t o;
    do_req(32'h0100, 32'd16, 2'd1, 3'd2, 0, o);
    do_req(32'h0200, 32'd16, 2'd1, 3'd2, 0, o);
    total_cnt++; if (outstanding !== 2'd2) $display("FAIL out_full: got %0d want 2", outstanding); else pass_cnt++;
    req_if.rd_req_valid  = 1'b1;
    req_if.rd_req_addr   = 32'h3000;
    req_if.rd_req_length = 32'd64;
    req_if.rd_req_burst  = 2'd1;
    req_if.rd_req_size   = 3'd2;
    for (int i = 0; i < 4; i++) begin
      tick;
      total_cnt++; if (ar_if.m_axi_arvalid !== 1'b0) $display("FAIL out_stall%0d: got %b want 0", i, ar_if.m_axi_arvalid); else pass_cnt++;
    end
    r_last_hs = 1'b1;
    tick;
    r_last_hs = 1'b0;
    exp_out = 1;
    total_cnt++; if (rd_resp_valid !== 1'b1) $display("FAIL out_resp: got %b want 1", rd_resp_valid); else pass_cnt++;
    total_cnt++; if (outstanding !== 2'd1) $display("FAIL out_drop: got %0d want 1", outstanding); else pass_cnt++;
    tick;
    total_cnt++; if ({ar_if.m_axi_arvalid, ar_if.m_axi_araddr, ar_if.m_axi_arlen} !== {1'b1, 32'h3000, 8'd15}) $display("FAIL out_release: got %b/%h/%0d want 1/3000/15", ar_if.m_axi_arvalid, ar_if.m_axi_araddr, ar_if.m_axi_arlen); else pass_cnt++;
    ar_if.m_axi_arready = 1'b1;
    r_last_hs = 1'b1;
    tick;
    ar_if.m_axi_arready = 1'b0;
    r_last_hs = 1'b0;
    total_cnt++; if (outstanding !== 2'd1) $display("FAIL out_simul: got %0d want 1", outstanding); else pass_cnt++;
    total_cnt++; if ({req_if.rd_req_ack, rd_resp_valid, req_if.rd_req_done} !== 3'b111) $display("FAIL out_ack_resp: got %b want 111", {req_if.rd_req_ack, rd_resp_valid, req_if.rd_req_done}); else pass_cnt++;
    req_if.rd_req_valid = 1'b0;
    tick;
    pulse_rlast;
  endtask

  task automatic test_reset_mid_burst;
    exp_t o;
    do_req(32'h4000, 32'd64, 2'd1, 3'd2, 0, o);
    req_if.rd_req_valid  = 1'b1;
    req_if.rd_req_addr   = 32'h5000;
    req_if.rd_req_length = 32'd32;
    tick;
    tick;
    total_cnt++; if (ar_if.m_axi_arvalid !== 1'b1) $display("FAIL rstmid_pre: got %b want 1", ar_if.m_axi_arvalid); else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    exp_out = 0;
    total_cnt++; if (ar_if.m_axi_arvalid !== 1'b0) $display("FAIL rstmid_arvalid: got %b want 0", ar_if.m_axi_arvalid); else pass_cnt++;
    total_cnt++; if (outstanding !== 2'd0) $display("FAIL rstmid_outstanding: got %0d want 0", outstanding); else pass_cnt++;
    req_if.rd_req_valid = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    total_cnt++; if (ar_if.m_axi_arvalid !== 1'b0) $display("FAIL rstmid_idle: got %b want 0", ar_if.m_axi_arvalid); else pass_cnt++;
    do_req(32'h6000, 32'd16, 2'd1, 3'd0, 0, o);
    pulse_rlast;
  endtask

  task automatic test_random;
    exp_t o, e;
    logic [31:0] addr, len;
    logic [1:0]  burst;
    logic [2:0]  size;
    for (int t = 0; t < 14; t++) begin
      size  = 3'($urandom_range(0, 2));
      burst = 2'($urandom_range(0, 2));
      addr  = 32'h0001_0000 + (32'($urandom_range(0, 3)) << 12);
      if ($urandom_range(0, 1) == 1) addr = addr + 32'hF00 + 32'($urandom_range(0, 255));
      else                           addr = addr + 32'($urandom_range(0, 4095));
      if (burst == 2'd0) addr = addr & ~((32'd1 << size) - 32'd1);
      len = 32'($urandom_range(0, 300));
      for (int k = 0; k < 40; k++) begin
        e = model(addr, len, burst, size);
        do_req(addr, len, burst, size, int'($urandom_range(0, 3)), o);
        if (exp_out == int'(MAXO) || $urandom_range(0, 1) == 1) pulse_rlast;
        if (e.done) break;
        addr = e.next_addr;
        len  = e.next_len;
      end
    end
    while (exp_out > 0) pulse_rlast;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    r_last_hs = 1'b0;
    req_if.rd_req_valid  = 1'b0;
    req_if.rd_req_addr   = '0;
    req_if.rd_req_length = '0;
    req_if.rd_req_burst  = '0;
    req_if.rd_req_size   = '0;
    ar_if.m_axi_arready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b0;
    tick;
    test_directed;
    test_zero_len;
    test_saturate;
    test_outstanding;
    test_reset_mid_burst;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
